c_retrieve: RTL and testbench

Retrieval controller for the warehouse rover's three-slot colour store. Accepts a colour pick request, locates the storage slot holding that colour, and commands the rover to that slot. When the rover arrives, it issues a one-cycle clear to the store and reports the result. It is the read/consume side of the slot store, which fills `pos1..pos3`, and sits between the pick-request source and the rover motion controller.

---
 rtl/c_store_pkg.sv | 24 ++
 rtl/c_slot_lookup.sv | 31 +++
 rtl/c_retrieve.sv | 149 ++++++++++++++
 tb/tb_c_retrieve.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/c_store_pkg.sv
// Shared definitions for the rover colour store: colour codes, slot indices
// and the retrieval FSM state type.
package c_store_pkg;

    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] RED   = 2'b01;
    localparam logic [1:0] GREEN = 2'b10;
    localparam logic [1:0] BLUE  = 2'b11;

    localparam logic [1:0] SLOT_NONE = 2'd0;
    localparam logic [1:0] SLOT1     = 2'd1;
    localparam logic [1:0] SLOT2     = 2'd2;
    localparam logic [1:0] SLOT3     = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        CMD,
        WAIT_ARRIVE,
        CLEAR,
        RESP
    } state_t;

endpackage

// File: rtl/c_slot_lookup.sv
// Combinational priority match of the three store slots against a colour;
// the lowest-numbered matching slot wins and EMPTY never matches.
module c_slot_lookup
    import c_store_pkg::*;
(
    input  logic [1:0] pos1,
    input  logic [1:0] pos2,
    input  logic [1:0] pos3,
    input  logic [1:0] color,
    output logic       hit,
    output logic [1:0] slot
);

    always_comb begin
        hit  = 1'b0;
        slot = SLOT_NONE;
        if (color != EMPTY) begin
            if (pos1 == color) begin
                hit  = 1'b1;
                slot = SLOT1;
            end else if (pos2 == color) begin
                hit  = 1'b1;
                slot = SLOT2;
            end else if (pos3 == color) begin
                hit  = 1'b1;
                slot = SLOT3;
            end
        end
    end

endmodule

// File: rtl/c_retrieve.sv
// Retrieval controller: finds a requested colour in the store, moves the rover
// there, clears the slot and reports. Optional arrival timeout: C_RETRIEVE_TIMEOUT_EN.
module c_retrieve
    import c_store_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] pos1,
    input  logic [1:0] pos2,
    input  logic [1:0] pos3,
    input  logic       req_valid,
    input  logic [1:0] req_color,
    output logic       req_ready,
    output logic       cmd_valid,
    output logic [1:0] cmd_slot,
    input  logic       cmd_ready,
    input  logic       arrive,
    output logic       clr_valid,
    output logic [1:0] clr_slot,
    output logic       resp_valid,
    output logic       resp_hit,
    output logic [1:0] resp_slot,
    output logic       resp_err
);

    if (TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t     state;
    logic [1:0] color_q;
    logic [1:0] slot_q;
    logic       lk_hit;
    logic [1:0] lk_slot;

    c_slot_lookup u_lookup (
        .pos1  (pos1),
        .pos2  (pos2),
        .pos3  (pos3),
        .color (color_q),
        .hit   (lk_hit),
        .slot  (lk_slot)
    );

`ifdef C_RETRIEVE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;
    logic             timeout;

    // Fires on the last permitted wait cycle so that an arrive in that same
    // cycle still takes priority.
    assign timeout = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign resp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            color_q    <= EMPTY;
            slot_q     <= SLOT_NONE;
            req_ready  <= 1'b1;
            cmd_valid  <= 1'b0;
            cmd_slot   <= SLOT_NONE;
            clr_valid  <= 1'b0;
            clr_slot   <= SLOT_NONE;
            resp_valid <= 1'b0;
            resp_hit   <= 1'b0;
            resp_slot  <= SLOT_NONE;
`ifdef C_RETRIEVE_TIMEOUT_EN
            wait_cnt   <= '0;
            resp_err   <= 1'b0;
`endif
        end else begin
            clr_valid  <= 1'b0;
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        color_q   <= req_color;
                        req_ready <= 1'b0;
                        state     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (lk_hit) begin
                        slot_q    <= lk_slot;
                        cmd_valid <= 1'b1;
                        cmd_slot  <= lk_slot;
                        state     <= CMD;
                    end else begin
                        resp_valid <= 1'b1;
                        resp_hit   <= 1'b0;
                        resp_slot  <= SLOT_NONE;
                        state      <= RESP;
                    end
                end
                CMD: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        cmd_slot  <= SLOT_NONE;
`ifdef C_RETRIEVE_TIMEOUT_EN
                        wait_cnt  <= '0;
`endif
                        state     <= WAIT_ARRIVE;
                    end
                end
                WAIT_ARRIVE: begin
                    if (arrive) begin
                        clr_valid <= 1'b1;
                        clr_slot  <= slot_q;
                        state     <= CLEAR;
                    end
`ifdef C_RETRIEVE_TIMEOUT_EN
                    else if (timeout) begin
                        resp_valid <= 1'b1;
                        resp_hit   <= 1'b0;
                        resp_slot  <= SLOT_NONE;
                        resp_err   <= 1'b1;
                        state      <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
`endif
                end
                CLEAR: begin
                    clr_slot   <= SLOT_NONE;
                    resp_valid <= 1'b1;
                    resp_hit   <= 1'b1;
                    resp_slot  <= slot_q;
                    state      <= RESP;
                end
                RESP: begin
                    resp_hit  <= 1'b0;
                    resp_slot <= SLOT_NONE;
`ifdef C_RETRIEVE_TIMEOUT_EN
                    resp_err  <= 1'b0;
`endif
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_c_retrieve.sv
// Self-checking bench for c_retrieve: directed scenarios plus randomized
// retrievals checked cycle by cycle against a behavioural slot-search model.
module tb_c_retrieve;
    import c_store_pkg::*;

`ifdef C_RETRIEVE_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 1024;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] pos1, pos2, pos3;
    logic       req_valid;
    logic [1:0] req_color;
    logic       req_ready;
    logic       cmd_valid;
    logic [1:0] cmd_slot;
    logic       cmd_ready;
    logic       arrive;
    logic       clr_valid;
    logic [1:0] clr_slot;
    logic       resp_valid;
    logic       resp_hit;
    logic [1:0] resp_slot;
    logic       resp_err;

    int errors = 0;
    int checks = 0;

    localparam logic [11:0] E_IDLE = 12'b1000_0000_0000;
    localparam logic [11:0] E_BUSY = 12'b0000_0000_0000;

    c_retrieve #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pos1       (pos1),
        .pos2       (pos2),
        .pos3       (pos3),
        .req_valid  (req_valid),
        .req_color  (req_color),
        .req_ready  (req_ready),
        .cmd_valid  (cmd_valid),
        .cmd_slot   (cmd_slot),
        .cmd_ready  (cmd_ready),
        .arrive     (arrive),
        .clr_valid  (clr_valid),
        .clr_slot   (clr_slot),
        .resp_valid (resp_valid),
        .resp_hit   (resp_hit),
        .resp_slot  (resp_slot),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    // Payload fields only matter while their valid is high.
    function automatic logic [11:0] norm(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        if (!r[10]) r[9:8] = 2'b00;
        if (!r[7])  r[6:5] = 2'b00;
        if (!r[4])  r[3:0] = 4'b0000;
        return r;
    endfunction

    function automatic logic [11:0] raw_outs();
        return {req_ready, cmd_valid, cmd_slot, clr_valid, clr_slot,
                resp_valid, resp_hit, resp_slot, resp_err};
    endfunction

    function automatic logic [11:0] outs();
        return norm(raw_outs());
    endfunction

    function automatic logic [11:0] e_cmd(input logic [1:0] s);
        return {1'b0, 1'b1, s, 8'b0};
    endfunction

    function automatic logic [11:0] e_clr(input logic [1:0] s);
        return {4'b0, 1'b1, s, 5'b0};
    endfunction

    function automatic logic [11:0] e_resp(input logic h, input logic [1:0] s, input logic er);
        return {7'b0, 1'b1, h, s, er};
    endfunction

    // Reference: first slot (1..3) holding the requested non-empty colour, else 0.
    function automatic logic [1:0] ref_slot(input logic [1:0] p1, input logic [1:0] p2,
                                            input logic [1:0] p3, input logic [1:0] c);
        logic [1:0] p [1:3];
        p[1] = p1; p[2] = p2; p[3] = p3;
        if (c == EMPTY) return 2'd0;
        for (int i = 1; i <= 3; i++)
            if (p[i] == c) return 2'(i);
        return 2'd0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic retrieve(input string tag, input logic [1:0] p1, input logic [1:0] p2,
                            input logic [1:0] p3, input logic [1:0] c,
                            input int cmd_dly, input int arr_dly, input bit scramble);
        logic [1:0]  s;
        logic [11:0] e;
        s = ref_slot(p1, p2, p3, c);
        pos1 = p1; pos2 = p2; pos3 = p3;
        e = E_IDLE; checks++;
        if (outs() !== e) begin errors++; $display("[TB] FAIL %s/idle0: got %b want %b", tag, outs(), e); end
        req_valid = 1'b1; req_color = c;
        step();
        req_valid = 1'b0;
        e = E_BUSY; checks++;
        if (outs() !== e) begin errors++; $display("[TB] FAIL %s/lookup: got %b want %b", tag, outs(), e); end
        step();
        if (s == 2'd0) begin
            e = e_resp(1'b0, 2'd0, 1'b0); checks++;
            if (outs() !== e) begin errors++; $display("[TB] FAIL %s/miss_resp: got %b want %b", tag, outs(), e); end
            step();
        end else begin
            if (scramble) begin
                pos1 = 2'($urandom_range(0, 3));
                pos2 = 2'($urandom_range(0, 3));
                pos3 = 2'($urandom_range(0, 3));
            end
            for (int d = 0; d <= cmd_dly; d++) begin
                e = e_cmd(s); checks++;
                if (outs() !== e) begin errors++; $display("[TB] FAIL %s/cmd%0d: got %b want %b", tag, d, outs(), e); end
                cmd_ready = (d == cmd_dly);
                if (d != cmd_dly) begin
                    req_valid = 1'b1;
                    req_color = 2'($urandom_range(0, 3));
                end
                step();
                cmd_ready = 1'b0;
                req_valid = 1'b0;
            end
            for (int w = 0; w <= arr_dly; w++) begin
                e = E_BUSY; checks++;
                if (outs() !== e) begin errors++; $display("[TB] FAIL %s/wait%0d: got %b want %b", tag, w, outs(), e); end
                arrive = (w == arr_dly);
                step();
                arrive = 1'b0;
            end
            e = e_clr(s); checks++;
            if (outs() !== e) begin errors++; $display("[TB] FAIL %s/clear: got %b want %b", tag, outs(), e); end
            step();
            e = e_resp(1'b1, s, 1'b0); checks++;
            if (outs() !== e) begin errors++; $display("[TB] FAIL %s/hit_resp: got %b want %b", tag, outs(), e); end
            step();
        end
        e = E_IDLE; checks++;
        if (outs() !== e) begin errors++; $display("[TB] FAIL %s/idle_end: got %b want %b", tag, outs(), e); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_color = EMPTY;
        cmd_ready = 1'b0; arrive = 1'b0;
        pos1 = EMPTY; pos2 = EMPTY; pos3 = EMPTY;
        #12;
        checks++;
        if (raw_outs() !== E_IDLE) begin errors++; $display("[TB] FAIL reset: got %b want %b", raw_outs(), E_IDLE); end
        rst_n = 1'b1;
        step();
        checks++;
        if (raw_outs() !== E_IDLE) begin errors++; $display("[TB] FAIL reset_release: got %b want %b", raw_outs(), E_IDLE); end
    endtask

    task automatic test_ignored_inputs();
        cmd_ready = 1'b1; arrive = 1'b1;
        step();
        cmd_ready = 1'b0; arrive = 1'b0;
        step();
        checks++;
        if (raw_outs() !== E_IDLE) begin errors++; $display("[TB] FAIL idle_ignore: got %b want %b", raw_outs(), E_IDLE); end
    endtask

    task automatic test_directed();
        retrieve("hit_green", BLUE, GREEN, RED, GREEN, 0, 0, 1'b0);
        retrieve("miss_blue", RED, EMPTY, EMPTY, BLUE, 0, 0, 1'b0);
        retrieve("cmd_stall", GREEN, GREEN, EMPTY, GREEN, 3, 1, 1'b0);
        retrieve("req_empty", EMPTY, RED, EMPTY, EMPTY, 0, 0, 1'b0);
        retrieve("latched", RED, RED, BLUE, RED, 2, 2, 1'b1);
        retrieve("slot3", EMPTY, GREEN, BLUE, BLUE, 1, 0, 1'b1);
    endtask

    task automatic test_midreset();
        logic [11:0] e;
        pos1 = RED; pos2 = BLUE; pos3 = GREEN;
        req_valid = 1'b1; req_color = BLUE;
        step();
        req_valid = 1'b0;
        step();
        e = e_cmd(2'd2); checks++;
        if (outs() !== e) begin errors++; $display("[TB] FAIL midrst_cmd: got %b want %b", outs(), e); end
        cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        checks++;
        if (raw_outs() !== E_IDLE) begin errors++; $display("[TB] FAIL midrst_async: got %b want %b", raw_outs(), E_IDLE); end
        #2 rst_n = 1'b1;
        step();
        arrive = 1'b1;
        step();
        arrive = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (raw_outs() !== E_IDLE) begin errors++; $display("[TB] FAIL midrst_after%0d: got %b want %b", k, raw_outs(), E_IDLE); end
            step();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++) begin
            retrieve($sformatf("rand%0d", i),
                     2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                     2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 5)),
                     1'($urandom_range(0, 1)));
        end
    endtask

`ifdef C_RETRIEVE_TIMEOUT_EN
    task automatic test_timeout();
        logic [11:0] e;
        pos1 = GREEN; pos2 = EMPTY; pos3 = BLUE;
        req_valid = 1'b1; req_color = BLUE;
        step();
        req_valid = 1'b0;
        step();
        e = e_cmd(2'd3); checks++;
        if (outs() !== e) begin errors++; $display("[TB] FAIL to_cmd: got %b want %b", outs(), e); end
        cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;
        for (int w = 1; w <= TO; w++) begin
            checks++;
            if (outs() !== E_BUSY) begin errors++; $display("[TB] FAIL to_wait%0d: got %b want %b", w, outs(), E_BUSY); end
            step();
        end
        e = e_resp(1'b0, 2'd0, 1'b1); checks++;
        if (outs() !== e) begin errors++; $display("[TB] FAIL to_resp: got %b want %b", outs(), e); end
        step();
        checks++;
        if (raw_outs() !== E_IDLE) begin errors++; $display("[TB] FAIL to_idle: got %b want %b", raw_outs(), E_IDLE); end
        retrieve("arrive_last", GREEN, EMPTY, BLUE, BLUE, 0, TO - 1, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_ignored_inputs();
        test_directed();
        test_midreset();
`ifdef C_RETRIEVE_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
